// File: rtl/timer_pkg.sv
// Shared types and parameter limits for the multi-channel auxiliary timer bank.
package timer_pkg;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } tmr_mode_e;

  localparam int N_CH_MIN     = 1;
  localparam int N_CH_MAX     = 16;
  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 16;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 256;

  // Prescaler counter width; a divider of 1 still needs a 1-bit register.
  function automatic int psc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/aux_timer_ch.sv
// One timer channel: loadable down-counter with one-shot or auto-reload
// behaviour and a registered single-cycle expiry pulse.
module aux_timer_ch
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             step,
  input  logic             ena,
  input  logic             loadN,
  input  tmr_mode_e        mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;

  // Next state: load beats count; a count of 0 is a resting state in both modes.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;
    if (!loadN) begin
      count_d  = data;
      reload_d = data;
    end else if (ena && step) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        expire_d = 1'b1;
        count_d  = (mode == PERIODIC) ? reload_q : '0;
      end
    end
  end

  // State registers; reset also drops any expiry that would have fired this edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  assign count  = count_q;
  assign expire = expire_q;

endmodule

// File: rtl/multi_aux_timer.sv
// Bank of N_CH independent down-counter timers sharing one prescaled tick.
module multi_aux_timer
  import timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  tick,
  input  logic [N_CH-1:0]       ena_cnt,
  input  logic [N_CH-1:0]       loadN,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*WIDTH-1:0] data_in,
  output logic [N_CH-1:0]       tc,
  output logic [N_CH-1:0]       expire,
  output logic                  any_tc
);

  localparam int PSC_W = psc_width(PRESCALE);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_param
    $error("multi_aux_timer: parameter out of range");
  end

  logic [PSC_W-1:0] psc_q, psc_d;
  logic             step;

  assign step = tick && (psc_q == PSC_W'(PRESCALE - 1));

  // Prescaler advances on every tick and wraps after the step; loads never touch it.
  always_comb begin
    psc_d = psc_q;
    if (tick) begin
      psc_d = step ? '0 : psc_q + PSC_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] count;

    aux_timer_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk    (clk),
      .resetN (resetN),
      .step   (step),
      .ena    (ena_cnt[i]),
      .loadN  (loadN[i]),
      .mode   (tmr_mode_e'(mode[i])),
      .data   (data_in[i*WIDTH +: WIDTH]),
      .count  (count),
      .expire (expire[i])
    );

    // Terminal count is held low during reset regardless of register contents.
    assign tc[i] = (count == '0) && resetN;
  end

  assign any_tc = |tc;

endmodule

// File: tb/tb_multi_aux_timer.sv
// Directed bench for multi_aux_timer: a PRESCALE=1 and a PRESCALE=4 instance
// driven by the same inputs, checked against hand-computed vectors.
module tb_multi_aux_timer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        tick;
  logic [3:0]  ena_cnt;
  logic [3:0]  loadN;
  logic [3:0]  mode;
  logic [31:0] data_in;

  logic [3:0] tc1, exp1, tc4, exp4;
  logic       any1, any4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_aux_timer #(.N_CH(4), .WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .resetN(resetN), .tick(tick), .ena_cnt(ena_cnt), .loadN(loadN),
    .mode(mode), .data_in(data_in), .tc(tc1), .expire(exp1), .any_tc(any1)
  );

  multi_aux_timer #(.N_CH(4), .WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .resetN(resetN), .tick(tick), .ena_cnt(ena_cnt), .loadN(loadN),
    .mode(mode), .data_in(data_in), .tc(tc4), .expire(exp4), .any_tc(any4)
  );

  typedef struct {
    logic        rstn;
    logic        tk;
    logic [3:0]  ena;
    logic [3:0]  ldn;
    logic [3:0]  md;
    logic [31:0] data;
    logic [3:0]  exp_tc;
    logic [3:0]  exp_ex;
  } vec_t;

  function automatic logic [31:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic drive(input logic rstn, input logic tk, input logic [3:0] ena,
                       input logic [3:0] ldn, input logic [3:0] md, input logic [31:0] data);
    resetN  = rstn;
    tick    = tk;
    ena_cnt = ena;
    loadN   = ldn;
    mode    = md;
    data_in = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] tc_a, input logic [3:0] ex_a,
                     input logic any_a, input logic [3:0] tc_e, input logic [3:0] ex_e);
    logic any_e;
    any_e = |tc_e;
    checks += 3;
    if (tc_a !== tc_e) begin
      errors++;
      $display("FAIL %s tc got %b want %b", name, tc_a, tc_e);
    end
    if (ex_a !== ex_e) begin
      errors++;
      $display("FAIL %s expire got %b want %b", name, ex_a, ex_e);
    end
    if (any_a !== any_e) begin
      errors++;
      $display("FAIL %s any_tc got %b want %b", name, any_a, any_e);
    end
  endtask

  vec_t vt[11];

  initial begin
    resetN = 1'b0; tick = 1'b0; ena_cnt = '0; loadN = '1; mode = '0; data_in = '0;

    // rstn tick ena loadN mode data exp_tc exp_expire
    vt[0]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0,         4'b0000, 4'b0000};
    vt[1]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0,         4'b1111, 4'b0000};
    vt[2]  = '{1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0010, pk(3,2,0,0),   4'b1100, 4'b0000};
    vt[3]  = '{1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0010, 32'h0,         4'b1100, 4'b0000};
    vt[4]  = '{1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0010, 32'h0,         4'b1100, 4'b0010};
    vt[5]  = '{1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0010, 32'h0,         4'b1101, 4'b0001};
    vt[6]  = '{1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0010, 32'h0,         4'b1101, 4'b0010};
    vt[7]  = '{1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0010, 32'h0,         4'b1101, 4'b0000};
    vt[8]  = '{1'b1, 1'b1, 4'b0011, 4'b1110, 4'b0010, pk(2,0,0,0),   4'b1100, 4'b0010};
    vt[9]  = '{1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0010, 32'h0,         4'b1100, 4'b0000};
    vt[10] = '{1'b1, 1'b1, 4'b0011, 4'b1110, 4'b0010, pk(5,0,0,0),   4'b1100, 4'b0010};

    @(posedge clk);
    #1;

    // One-shot countdown, periodic reload, load racing a count==1 step.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rstn, vt[i].tk, vt[i].ena, vt[i].ldn, vt[i].md, vt[i].data);
      chk($sformatf("vec%0d", i), tc1, exp1, any1, vt[i].exp_tc, vt[i].exp_ex);
    end

    // Pause: ch0=5, ch1=2 frozen for 10 ticks.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0010, 32'h0);
      chk($sformatf("pause%0d", i), tc1, exp1, any1, 4'b1100, 4'b0000);
    end

    // Resume ch0 only: 5 steps to zero, expiry together with tc.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 4'b0001, 4'b1111, 4'b0010, 32'h0);
      chk($sformatf("resume%0d", i), tc1, exp1, any1,
          (i >= 5) ? 4'b1101 : 4'b1100, (i == 5) ? 4'b0001 : 4'b0000);
    end

    // Reset mid-count: ch0=7 one-shot, ch2=1 periodic, ch3=4 periodic, ch1 keeps 2.
    drive(1'b1, 1'b0, 4'b0000, 4'b0010, 4'b1110, pk(7,0,1,4));
    chk("rst_load", tc1, exp1, any1, 4'b0000, 4'b0000);
    drive(1'b1, 1'b1, 4'b1101, 4'b1111, 4'b1110, 32'h0);
    chk("rst_pre", tc1, exp1, any1, 4'b0000, 4'b0100);
    drive(1'b0, 1'b1, 4'b1101, 4'b0000, 4'b1110, pk(9,9,9,9));
    chk("rst_edge", tc1, exp1, any1, 4'b0000, 4'b0000);
    chk("rst_edge4", tc4, exp4, any4, 4'b0000, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0);
    chk("rst_hold", tc1, exp1, any1, 4'b0000, 4'b0000);
    drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0);
    chk("rst_rel", tc1, exp1, any1, 4'b1111, 4'b0000);

    // Periodic loaded 0 stays idle; periodic loaded 1 expires every step.
    drive(1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0011, pk(0,1,0,0));
    chk("p01_load", tc1, exp1, any1, 4'b1101, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'b0011, 4'b1111, 4'b0011, 32'h0);
      chk($sformatf("p01_step%0d", i), tc1, exp1, any1, 4'b1101, 4'b0010);
    end
    drive(1'b1, 1'b0, 4'b0011, 4'b1111, 4'b0011, 32'h0);
    chk("p01_idle", tc1, exp1, any1, 4'b1101, 4'b0000);

    // PRESCALE=4: ch0 loaded 2 reaches zero after exactly 8 ticks; ch2 reload mid-run.
    drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0);
    drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 32'h0);
    chk("ps_rel4", tc4, exp4, any4, 4'b1111, 4'b0000);
    drive(1'b1, 1'b0, 4'b0001, 4'b1110, 4'b0000, pk(2,0,0,0));
    chk("ps_load4", tc4, exp4, any4, 4'b1110, 4'b0000);
    chk("ps_load1", tc1, exp1, any1, 4'b1110, 4'b0000);
    for (int t = 1; t <= 9; t++) begin
      drive(1'b1, 1'b1, 4'b0001, (t == 3) ? 4'b1011 : 4'b1111, 4'b0000, pk(0,0,9,0));
      chk($sformatf("ps_tick%0d", t), tc4, exp4, any4,
          (t >= 8) ? 4'b1011 : ((t >= 3) ? 4'b1010 : 4'b1110),
          (t == 8) ? 4'b0001 : 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
